// File: rtl/sc_point_pkg.sv
// Shared constants for the point FSM and its datapath responder.
package sc_point_pkg;

    // Shift-selection codes driven by the point FSM
    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    // Move-timer states
    typedef enum logic {
        TIMER_COUNTING = 1'b0,
        TIMER_PENDING  = 1'b1
    } timerState_t;

endpackage : sc_point_pkg

// File: rtl/sc_movetimer.sv
// Move-request timer: counts TIMER_TICKS cycles, then holds an active-low
// request until a load acknowledges it. Clear or reset restarts the period.
module sc_movetimer
    import sc_point_pkg::*;
#(
    parameter int unsigned TIMER_TICKS = 50_000_000,
    parameter int unsigned TIMERWIDTH  = 26
) (
    input  logic SC_MOVETIMER_CLOCK_50,
    input  logic SC_MOVETIMER_RESET_InHigh,
    input  logic SC_MOVETIMER_clear_InLow,
    input  logic SC_MOVETIMER_ack_InLow,
    output logic SC_MOVETIMER_T0_OutLow
);

    localparam logic [TIMERWIDTH-1:0] TERMINALCOUNT = TIMERWIDTH'(TIMER_TICKS - 1);

    timerState_t           timerState;
    timerState_t           timerStateNext;
    logic [TIMERWIDTH-1:0] timerCount;
    logic [TIMERWIDTH-1:0] timerCountNext;
    logic                  t0OutLowNext;

    // State, counter and request register
    always_ff @(posedge SC_MOVETIMER_CLOCK_50) begin
        if (SC_MOVETIMER_RESET_InHigh) begin
            timerState             <= TIMER_COUNTING;
            timerCount             <= '0;
            SC_MOVETIMER_T0_OutLow <= 1'b1;
        end else begin
            timerState             <= timerStateNext;
            timerCount             <= timerCountNext;
            SC_MOVETIMER_T0_OutLow <= t0OutLowNext;
        end
    end

    // Next state: clear/ack restart the period and win over terminal count
    always_comb begin
        timerStateNext = timerState;
        timerCountNext = timerCount;
        if (!SC_MOVETIMER_clear_InLow || !SC_MOVETIMER_ack_InLow) begin
            timerStateNext = TIMER_COUNTING;
            timerCountNext = '0;
        end else begin
            case (timerState)
                TIMER_COUNTING: begin
                    if (timerCount == TERMINALCOUNT) begin
                        timerStateNext = TIMER_PENDING;
                    end else begin
                        timerCountNext = timerCount + TIMERWIDTH'(1);
                    end
                end
                TIMER_PENDING: begin
                    timerCountNext = timerCount;
                end
                default: begin
                    timerStateNext = TIMER_COUNTING;
                    timerCountNext = '0;
                end
            endcase
        end
    end

    // Output: request is active (low) whenever the timer sits in PENDING
    always_comb begin
        t0OutLowNext = 1'b1;
        if (timerStateNext == TIMER_PENDING) begin
            t0OutLowNext = 1'b0;
        end
    end

endmodule : sc_movetimer

// File: rtl/sc_pointregister.sv
// Point datapath: one-hot column register, row counter and move-request timer
// serving the point-control FSM.
module sc_pointregister
    import sc_point_pkg::*;
#(
    parameter int unsigned          DATAWIDTH   = 8,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE  = DATAWIDTH'(8'b0001_0000),
    parameter int unsigned          ROWS        = 8,
    parameter int unsigned          ROWWIDTH    = 3,
    parameter int unsigned          TIMER_TICKS = 50_000_000,
    parameter int unsigned          TIMERWIDTH  = 26
) (
    input  logic                 SC_POINTREGISTER_CLOCK_50,
    input  logic                 SC_POINTREGISTER_RESET_InHigh,
    input  logic                 SC_POINTREGISTER_clear_InLow,
    input  logic                 SC_POINTREGISTER_load_InLow,
    input  logic [1:0]           SC_POINTREGISTER_shiftselection_In,
    output logic [DATAWIDTH-1:0] SC_POINTREGISTER_data_Out,
    output logic [ROWWIDTH-1:0]  SC_POINTREGISTER_row_Out,
    output logic                 SC_POINTREGISTER_T0_OutLow
);

    localparam logic [ROWWIDTH-1:0] LASTROW = ROWWIDTH'(ROWS - 1);

    logic [DATAWIDTH-1:0] dataNext;
    logic [ROWWIDTH-1:0]  rowNext;

    // Column shift: saturate at either edge so the point is never lost
    always_comb begin
        dataNext = SC_POINTREGISTER_data_Out;
        case (SC_POINTREGISTER_shiftselection_In)
            SHIFT_LEFT: begin
                if (!SC_POINTREGISTER_data_Out[DATAWIDTH-1]) begin
                    dataNext = {SC_POINTREGISTER_data_Out[DATAWIDTH-2:0], 1'b0};
                end
            end
            SHIFT_RIGHT: begin
                if (!SC_POINTREGISTER_data_Out[0]) begin
                    dataNext = {1'b0, SC_POINTREGISTER_data_Out[DATAWIDTH-1:1]};
                end
            end
            SHIFT_NONE, SHIFT_HOLD: begin
                dataNext = SC_POINTREGISTER_data_Out;
            end
            default: begin
                dataNext = SC_POINTREGISTER_data_Out;
            end
        endcase
    end

    // Row advance on load, wrapping from the last row back to 0
    always_comb begin
        rowNext = SC_POINTREGISTER_row_Out;
        if (!SC_POINTREGISTER_load_InLow) begin
            if (SC_POINTREGISTER_row_Out == LASTROW) begin
                rowNext = '0;
            end else begin
                rowNext = SC_POINTREGISTER_row_Out + ROWWIDTH'(1);
            end
        end
    end

    // Column and row registers; clear overrides shift and load
    always_ff @(posedge SC_POINTREGISTER_CLOCK_50) begin
        if (SC_POINTREGISTER_RESET_InHigh || !SC_POINTREGISTER_clear_InLow) begin
            SC_POINTREGISTER_data_Out <= INIT_VALUE;
            SC_POINTREGISTER_row_Out  <= '0;
        end else begin
            SC_POINTREGISTER_data_Out <= dataNext;
            SC_POINTREGISTER_row_Out  <= rowNext;
        end
    end

    sc_movetimer #(
        .TIMER_TICKS (TIMER_TICKS),
        .TIMERWIDTH  (TIMERWIDTH)
    ) u_moveTimer (
        .SC_MOVETIMER_CLOCK_50     (SC_POINTREGISTER_CLOCK_50),
        .SC_MOVETIMER_RESET_InHigh (SC_POINTREGISTER_RESET_InHigh),
        .SC_MOVETIMER_clear_InLow  (SC_POINTREGISTER_clear_InLow),
        .SC_MOVETIMER_ack_InLow    (SC_POINTREGISTER_load_InLow),
        .SC_MOVETIMER_T0_OutLow    (SC_POINTREGISTER_T0_OutLow)
    );

endmodule : sc_pointregister
